// File: rtl/pixel_issue_sequencer_pkg.sv
// pixel_issue_sequencer_pkg: shared raster defaults, field widths and the pixel request record
package pixel_issue_sequencer_pkg;
    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;
    localparam int CREDITS_DEF = 64;
    localparam int X_W         = 10;
    localparam int Y_W         = 9;
    localparam int ID_W        = 19;

    typedef struct packed {
        logic [X_W-1:0]  x;
        logic [Y_W-1:0]  y;
        logic [ID_W-1:0] id;
        logic            last;
    } pixel_req_t;
endpackage

// File: rtl/pixel_issue_sequencer_credit.sv
// pixel_credit_counter: pixel-buffer credit tracker with full/empty flags and sticky overflow error
//   clk, rst (async, active-low) | dec: pixel issued | inc: buffer entry popped
//   full: all credits home | empty: no credit left | err: return seen while full
module pixel_credit_counter #(
    parameter int  CREDITS = 64,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic dec,
    input  logic inc,
    output logic full,
    output logic empty,
    output logic err
);
    logic [CW-1:0] r_count;
    logic          r_err;

    assign full  = (r_count == CW'(CREDITS));
    assign empty = (r_count == '0);
    assign err   = r_err;

    // A simultaneous issue and return cancel out; a lone return at full is dropped and flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= CW'(CREDITS);
            r_err   <= 1'b0;
        end else if (inc && !dec) begin
            if (full) r_err <= 1'b1;
            else      r_count <= r_count + 1'b1;
        end else if (dec && !inc && !empty) begin
            r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: rtl/pixel_issue_sequencer.sv
// pixel_issue_sequencer: raster-order pixel request issuer, throttled by pixel-buffer credits
//   clk, rst (async, active-low) | render_frame: frame start pulse
//   pix_ready: raypipe accepts | pb_re: credit return from frame buffer handler
//   pix_valid/pix_x/pix_y/pix_id/pix_last: pixel request | busy, frame_done, credit_err: status
module pixel_issue_sequencer
    import pixel_issue_sequencer_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int CREDITS = CREDITS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            render_frame,
    input  logic            pix_ready,
    input  logic            pb_re,
    output logic            pix_valid,
    output logic [X_W-1:0]  pix_x,
    output logic [Y_W-1:0]  pix_y,
    output logic [ID_W-1:0] pix_id,
    output logic            pix_last,
    output logic            busy,
    output logic            frame_done,
    output logic            credit_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

    state_t          r_state;
    logic [X_W-1:0]  r_x;
    logic [Y_W-1:0]  r_y;
    logic [ID_W-1:0] r_id;
    logic            r_frame_done;
    logic            w_full;
    logic            w_empty;
    logic            w_err;
    logic            w_fire;
    logic            w_last;
    pixel_req_t      w_req;

    assign w_last     = (r_x == X_MAX) && (r_y == Y_MAX);
    assign w_req      = '{x: r_x, y: r_y, id: r_id, last: w_last};
    // Valid only depends on registered state, so a stalled request can never be withdrawn.
    assign pix_valid  = (r_state == ISSUE) && !w_empty;
    assign w_fire     = pix_valid && pix_ready;
    assign pix_x      = w_req.x;
    assign pix_y      = w_req.y;
    assign pix_id     = w_req.id;
    assign pix_last   = w_req.last;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;
    assign credit_err = w_err;

    pixel_credit_counter #(.CREDITS(CREDITS)) u_credits (
        .clk   (clk),
        .rst   (rst),
        .dec   (w_fire),
        .inc   (pb_re),
        .full  (w_full),
        .empty (w_empty),
        .err   (w_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_id         <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE:  if (render_frame) r_state <= ISSUE;
                ISSUE: if (w_fire) begin
                    r_x  <= (r_x == X_MAX) ? '0 : r_x + 1'b1;
                    r_y  <= w_last ? '0 : (r_x == X_MAX) ? r_y + 1'b1 : r_y;
                    r_id <= w_last ? '0 : r_id + 1'b1;
                    if (w_last) r_state <= DRAIN;
                end
                // The frame is complete only once every issued pixel has been consumed.
                DRAIN: if (w_full) begin
                    r_state      <= IDLE;
                    r_frame_done <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_issue_sequencer.sv
// tb_pixel_issue_sequencer: directed self-checking bench on a 16x16 raster with 64 credits
module tb_pixel_issue_sequencer;
    localparam int HR = 16;
    localparam int VR = 16;
    localparam int NP = HR * VR;

    logic        clk = 1'b0;
    logic        rst;
    logic        render_frame;
    logic        pix_ready;
    logic        pb_re;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [18:0] pix_id;
    logic        pix_last;
    logic        busy;
    logic        frame_done;
    logic        credit_err;

    int n_vec = 0;
    int n_err = 0;
    int exp_id, fd_cnt, fd_at, hs_at, n_hs;
    logic hs, prev_hs, drn_done;

    pixel_issue_sequencer #(.H_RES(HR), .V_RES(VR), .CREDITS(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .render_frame (render_frame),
        .pix_ready    (pix_ready),
        .pb_re        (pb_re),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_id       (pix_id),
        .pix_last     (pix_last),
        .busy         (busy),
        .frame_done   (frame_done),
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic count_hs(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            if (pix_valid && pix_ready) n++;
            tick();
        end
    endtask

    task automatic do_reset;
        render_frame = 1'b0;
        pix_ready    = 1'b0;
        pb_re        = 1'b0;
        rst          = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic start_frame;
        render_frame = 1'b1;
        tick();
        render_frame = 1'b0;
    endtask

    initial begin
        rst = 1'b1; render_frame = 1'b0; pix_ready = 1'b0; pb_re = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("rst_outputs", {pix_valid, pix_last, busy, frame_done, credit_err}, 5'b0);
        chk("rst_xyid", {pix_x, pix_y, pix_id}, 38'b0);
        tick();
        rst = 1'b1;
        tick();
        chk("idle_stays", busy, 1'b0);

        // Full frame with one-cycle-delayed credit returns; extra render_frame in ISSUE and DRAIN.
        pix_ready = 1'b1;
        start_frame();
        chk("start_valid", pix_valid, 1'b1);
        chk("start_busy", busy, 1'b1);
        exp_id = 0; fd_cnt = 0; fd_at = -1; hs_at = -1; prev_hs = 1'b0; drn_done = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            hs = pix_valid && pix_ready;
            if (hs) begin
                chk("frame_pix", {pix_x, pix_y, pix_id, pix_last},
                    {10'(exp_id % HR), 9'(exp_id / HR), 19'(exp_id), 1'(exp_id == NP - 1)});
                exp_id++;
                hs_at = c;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_at = c;
            end
            if (exp_id == NP && !busy) break;
            render_frame = (exp_id == 21) || (exp_id == NP && !drn_done);
            if (exp_id == NP) drn_done = 1'b1;
            pb_re   = prev_hs;
            prev_hs = hs;
            tick();
        end
        render_frame = 1'b0; pb_re = 1'b0;
        chk("frame_count", exp_id, NP);
        chk("frame_done_cnt", fd_cnt, 1);
        chk("frame_done_lat", fd_at - hs_at, 3);
        tick();
        chk("frame_done_pulse", frame_done, 1'b0);
        repeat (3) tick();
        chk("drain_render_ignored", busy, 1'b0);

        // No credit returns: exactly 64 issues, then one return buys exactly one more.
        do_reset();
        pix_ready = 1'b1;
        start_frame();
        count_hs(80, n_hs);
        chk("exhaust_hs", n_hs, 64);
        chk("exhaust_valid", pix_valid, 1'b0);
        start_frame();
        chk("issue_render_ignored", {busy, pix_id}, {1'b1, 19'd64});
        pb_re = 1'b1;
        tick();
        pb_re = 1'b0;
        count_hs(10, n_hs);
        chk("one_more_hs", n_hs, 1);
        chk("one_more_id", pix_id, 65);

        // Stall across the row wrap.
        do_reset();
        pix_ready = 1'b1;
        start_frame();
        for (int c = 0; c < 40 && pix_id != 19'd15; c++) tick();
        pix_ready = 1'b0;
        chk("wrap_at", {pix_valid, pix_x, pix_y, pix_id, pix_last}, {1'b1, 10'd15, 9'd0, 19'd15, 1'b0});
        tick();
        chk("wrap_stall1", {pix_valid, pix_x, pix_y, pix_id, pix_last}, {1'b1, 10'd15, 9'd0, 19'd15, 1'b0});
        tick();
        chk("wrap_stall2", {pix_valid, pix_x, pix_y, pix_id, pix_last}, {1'b1, 10'd15, 9'd0, 19'd15, 1'b0});
        pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
        chk("wrap_next", {pix_valid, pix_x, pix_y, pix_id, pix_last}, {1'b1, 10'd0, 9'd1, 19'd16, 1'b0});
        tick();
        chk("wrap_stall3", {pix_valid, pix_x, pix_y, pix_id, pix_last}, {1'b1, 10'd0, 9'd1, 19'd16, 1'b0});

        // Credits at 10: simultaneous issue and return keeps 10; overflow return flags credit_err.
        do_reset();
        pix_ready = 1'b1;
        start_frame();
        repeat (54) tick();
        chk("c10_id", pix_id, 54);
        pb_re = 1'b1;
        tick();
        pb_re = 1'b0;
        chk("c10_simul_id", pix_id, 55);
        count_hs(20, n_hs);
        chk("c10_remaining", n_hs, 10);
        chk("c10_valid", pix_valid, 1'b0);
        pix_ready = 1'b0;
        pb_re = 1'b1;
        repeat (64) tick();
        pb_re = 1'b0;
        chk("refill_err", credit_err, 1'b0);
        chk("refill_valid", pix_valid, 1'b1);
        pb_re = 1'b1;
        tick();
        pb_re = 1'b0;
        chk("overflow_err", credit_err, 1'b1);
        pix_ready = 1'b1;
        count_hs(80, n_hs);
        chk("overflow_credits", n_hs, 64);
        chk("overflow_id", pix_id, 129);
        chk("err_sticky", credit_err, 1'b1);

        // Asynchronous reset mid-frame.
        do_reset();
        chk("reset_clears_err", credit_err, 1'b0);
        pix_ready = 1'b1;
        start_frame();
        prev_hs = 1'b0;
        for (int c = 0; c < 300 && pix_id != 19'd100; c++) begin
            hs = pix_valid && pix_ready;
            pb_re   = prev_hs;
            prev_hs = hs;
            tick();
        end
        pb_re = 1'b0;
        chk("mid_id", pix_id, 100);
        #3 rst = 1'b0;
        #1;
        chk("async_rst", {pix_valid, busy, frame_done, pix_id}, {3'b000, 19'd0});
        tick();
        rst = 1'b1;
        tick();
        chk("no_done_after_rst", {busy, frame_done}, 2'b00);
        start_frame();
        chk("restart", {pix_valid, pix_x, pix_y, pix_id}, {1'b1, 10'd0, 9'd0, 19'd0});
        count_hs(80, n_hs);
        chk("restart_credits", n_hs, 64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pixel_issue_sequencer.md
PIXEL_ISSUE_SEQUENCER -- requirements
Module: pixel_issue_sequencer

Interface
REQ-001 Parameter H_RES, default 640, pixels per row.
REQ-002 Parameter V_RES, default 480, rows per frame.
REQ-003 Parameter CREDITS, default 64, pixel-buffer FIFO depth (max rays in flight).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 render_frame  input  1  one-cycle frame start request from camera control.
REQ-007 pix_ready  input  1  raypipe accepts the presented pixel.
REQ-008 pb_re  input  1  frame buffer handler popped one pixel-buffer entry (credit return).
REQ-009 pix_valid  output  1  pixel request presented.
REQ-010 pix_x  output  10  column, 0..H_RES-1.
REQ-011 pix_y  output  9  row, 0..V_RES-1.
REQ-012 pix_id  output  19  linear index y*H_RES+x, 0..307199.
REQ-013 pix_last  output  1  presented pixel is the final pixel of the frame.
REQ-014 busy  output  1  state is not IDLE.
REQ-015 frame_done  output  1  one-cycle pulse at frame completion.
REQ-016 credit_err  output  1  sticky; credit return seen while credits full.

Function
REQ-017 States: IDLE, ISSUE, DRAIN.
REQ-018 IDLE: render_frame=1 -> ISSUE next cycle with x=0, y=0, id=0; otherwise stay.
REQ-019 pix_valid = (state==ISSUE) && (credits>0); first pix_valid visible the cycle after render_frame is sampled.
REQ-020 Handshake fires on pix_valid && pix_ready; at the firing edge credits decrement by 1 and x/y/id advance.
REQ-021 While pix_valid=1 and pix_ready=0, pix_x/pix_y/pix_id/pix_last hold stable and pix_valid stays high.
REQ-022 Advance: x+1; at x==H_RES-1, x->0 and y+1; id+1 every handshake, never computed by multiply.
REQ-023 pix_last = (x==H_RES-1) && (y==V_RES-1).
REQ-024 Handshake with pix_last=1 -> DRAIN; counters return to 0.
REQ-025 pb_re=1 increments credits by 1 in any state; simultaneous handshake and pb_re leave credits unchanged.
REQ-026 pb_re while credits==CREDITS and no handshake: credits unchanged, credit_err set until reset.
REQ-027 DRAIN: when credits==CREDITS (all issued pixels consumed) -> IDLE and frame_done=1 for exactly that one cycle.
REQ-028 render_frame while busy=1 is ignored (no queueing).
REQ-029 credits register width $clog2(CREDITS+1); never below 0 or above CREDITS.
REQ-030 With CREDITS exhausted, pix_valid deasserts only between handshakes, never with an unaccepted pixel pending.

Reset
REQ-031 rst low asynchronously forces state=IDLE, x=0, y=0, id=0, credits=CREDITS, credit_err=0.
REQ-032 Reset values of outputs: pix_valid=0, pix_last=0, busy=0, frame_done=0, credit_err=0, pix_x=0, pix_y=0, pix_id=0.
REQ-033 Reset mid-frame abandons the frame; no frame_done is generated for it.

Structure
REQ-034 Shared package holds H_RES/V_RES defaults, the pixel-ID width (19), and a pixel_req_t struct {x, y, id, last}.
REQ-035 State enum is local to the module.
REQ-036 One sub-module: pixel_credit_counter (credit up/down, full/empty flags, error flag).
REQ-037 All registers use the team's async-reset flop primitive.

Verification
REQ-038 Reset, render_frame pulse, pix_ready=1, pb_re one cycle after each handshake -> 307200 handshakes, ids 0..307199 in order, pix_last only on id 307199 (x=639, y=479), one frame_done.
REQ-039 Never assert pb_re, pix_ready=1 -> exactly 64 handshakes then pix_valid=0; one pb_re -> exactly one more handshake.
REQ-040 Toggle pix_ready randomly during row wrap at x=639 -> outputs stable while stalled; next accepted pixel x=0, y+1, id+1.
REQ-041 Same-cycle handshake and pb_re with credits=10 -> credits stay 10; pb_re with credits=64 -> credit_err=1, credits 64.
REQ-042 render_frame during ISSUE and during DRAIN -> ignored; frame_done pulses once, one cycle after last credit returns.
REQ-043 rst low at id=1000 -> same cycle pix_valid=0, busy=0, credits=64; new render_frame restarts at id 0.
